// File: rtl/alu_acc_ctrl_pkg.sv
// Shared types and constants for the ALU accumulator controller and its bench stub.
package alu_acc_ctrl_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int SEL_W_DEF = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam logic [SEL_W_DEF-1:0] SEL_AND = 3'd0;
    localparam logic [SEL_W_DEF-1:0] SEL_ADD = 3'd2;

endpackage

// File: rtl/alu_acc_ctrl_if.sv
// Command handshake bundle: one operand/select/load command per valid&ready edge.
interface alu_acc_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_operand;
    logic [SEL_W-1:0] cmd_sel;
    logic             cmd_load;

    modport master (
        output cmd_valid,
        output cmd_operand,
        output cmd_sel,
        output cmd_load,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_operand,
        input  cmd_sel,
        input  cmd_load,
        output cmd_ready
    );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Sequences commands into an external combinational ALU and writes its result
// back into a registered accumulator with zero flag, done pulse and op counter.
module alu_acc_ctrl
    import alu_acc_ctrl_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SEL_W       = SEL_W_DEF,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_acc_ctrl_if.slave    cmd,
    input  logic             clr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] acc,
    output logic             zero,
    output logic             done,
    output logic [7:0]       op_count
);

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [7:0]       op_count_q, op_count_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] result;

    assign cmd.cmd_ready = (state_q == ST_IDLE) && !clr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        op_count_d = op_count_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        load_d     = load_q;
        result     = load_q ? alu_b_q : alu_out;

        unique case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    acc_d  = '0;
                    zero_d = 1'b1;
                end else if (cmd.cmd_valid) begin
                    alu_a_d   = acc_q;
                    alu_b_d   = cmd.cmd_operand;
                    alu_sel_d = cmd.cmd_sel;
                    load_d    = cmd.cmd_load;
                    cnt_d     = CNT_INIT;
                    state_d   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    acc_d   = result;
                    zero_d  = (result == '0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (op_count_q != 8'hFF) begin
                        op_count_d = op_count_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            zero_q     <= 1'b1;
            done_q     <= 1'b0;
            op_count_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            op_count_q <= op_count_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            load_q     <= load_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign acc      = acc_q;
    assign zero     = zero_q;
    assign done     = done_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed bench: two controllers (settle 1 and 3 cycles), each around a stub ALU.
module tb_alu_acc_ctrl;
    import alu_acc_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic       rst_v   [2];
    logic       valid_v [2];
    logic       load_v  [2];
    logic [2:0] sel_v   [2];
    logic [3:0] opd_v   [2];
    logic       clr_v   [2];

    logic       rdy   [2];
    logic [3:0] a_o   [2];
    logic [3:0] b_o   [2];
    logic [2:0] sel_o [2];
    logic [3:0] out_i [2];
    logic [3:0] acc_o [2];
    logic       zero_o[2];
    logic       done_o[2];
    logic [7:0] cnt_o [2];

    function automatic logic [3:0] stub_alu(logic [3:0] a, logic [3:0] b, logic [2:0] s);
        if (s == SEL_ADD) return a + b;
        if (s == SEL_AND) return a & b;
        return 4'h0;
    endfunction

    alu_acc_ctrl_if #(.WIDTH(4), .SEL_W(3)) if0 ();
    alu_acc_ctrl_if #(.WIDTH(4), .SEL_W(3)) if1 ();

    assign if0.cmd_valid   = valid_v[0];
    assign if0.cmd_load    = load_v[0];
    assign if0.cmd_sel     = sel_v[0];
    assign if0.cmd_operand = opd_v[0];
    assign rdy[0]          = if0.cmd_ready;
    assign if1.cmd_valid   = valid_v[1];
    assign if1.cmd_load    = load_v[1];
    assign if1.cmd_sel     = sel_v[1];
    assign if1.cmd_operand = opd_v[1];
    assign rdy[1]          = if1.cmd_ready;

    assign out_i[0] = stub_alu(a_o[0], b_o[0], sel_o[0]);
    assign out_i[1] = stub_alu(a_o[1], b_o[1], sel_o[1]);

    alu_acc_ctrl #(.WIDTH(4), .SEL_W(3), .EXEC_CYCLES(1)) dut0 (
        .clk(clk), .reset(rst_v[0]), .cmd(if0.slave), .clr(clr_v[0]),
        .alu_a(a_o[0]), .alu_b(b_o[0]), .alu_sel(sel_o[0]), .alu_out(out_i[0]),
        .acc(acc_o[0]), .zero(zero_o[0]), .done(done_o[0]), .op_count(cnt_o[0])
    );

    alu_acc_ctrl #(.WIDTH(4), .SEL_W(3), .EXEC_CYCLES(3)) dut1 (
        .clk(clk), .reset(rst_v[1]), .cmd(if1.slave), .clr(clr_v[1]),
        .alu_a(a_o[1]), .alu_b(b_o[1]), .alu_sel(sel_o[1]), .alu_out(out_i[1]),
        .acc(acc_o[1]), .zero(zero_o[1]), .done(done_o[1]), .op_count(cnt_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Presents a command at a negedge and returns 1ns after the accepting edge.
    task automatic issue(input int d, input logic ld, input logic [2:0] s, input logic [3:0] opd);
        @(negedge clk);
        valid_v[d] = 1'b1;
        load_v[d]  = ld;
        sel_v[d]   = s;
        opd_v[d]   = opd;
        for (int i = 0; i < 20 && !rdy[d]; i++) @(negedge clk);
        if (!rdy[d]) check("accept_timeout", 32'(rdy[d]), 32'd1);
        @(posedge clk);
        #1;
        valid_v[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; valid_v[d] = 1'b0; load_v[d] = 1'b0;
            sel_v[d] = 3'd0; opd_v[d] = 4'h0; clr_v[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        @(posedge clk); #1;
        check("rst_acc",   32'(acc_o[0]),  32'h0);
        check("rst_zero",  32'(zero_o[0]), 32'h1);
        check("rst_done",  32'(done_o[0]), 32'h0);
        check("rst_ready", 32'(rdy[0]),    32'h1);
        check("rst_cnt",   32'(cnt_o[0]),  32'h0);

        // EXEC_CYCLES=1: load 5, add 6, add 5 (wraps to 0)
        issue(0, 1'b1, SEL_ADD, 4'h5);
        check("ld_busy", 32'(rdy[0]), 32'h0);
        @(posedge clk); #1;
        check("ld_acc",   32'(acc_o[0]),  32'h5);
        check("ld_done",  32'(done_o[0]), 32'h1);
        check("ld_zero",  32'(zero_o[0]), 32'h0);
        check("ld_ready", 32'(rdy[0]),    32'h1);
        issue(0, 1'b0, SEL_ADD, 4'h6);
        check("add_done_low", 32'(done_o[0]), 32'h0);
        check("add_a",   32'(a_o[0]),   32'h5);
        check("add_b",   32'(b_o[0]),   32'h6);
        check("add_sel", 32'(sel_o[0]), 32'(SEL_ADD));
        @(posedge clk); #1;
        check("add_acc",  32'(acc_o[0]),  32'hB);
        check("add_done", 32'(done_o[0]), 32'h1);
        check("add_cnt",  32'(cnt_o[0]),  32'h2);
        issue(0, 1'b0, SEL_ADD, 4'h5);
        @(posedge clk); #1;
        check("wrap_acc",  32'(acc_o[0]),  32'h0);
        check("wrap_zero", 32'(zero_o[0]), 32'h1);
        check("wrap_cnt",  32'(cnt_o[0]),  32'h3);
        @(posedge clk); #1;
        check("done_once", 32'(done_o[0]), 32'h0);

        // clr beats a simultaneous command, which is then taken once clr drops
        issue(0, 1'b1, SEL_ADD, 4'h7);
        @(posedge clk); #1;
        check("pre_clr_acc", 32'(acc_o[0]), 32'h7);
        @(negedge clk);
        clr_v[0] = 1'b1; valid_v[0] = 1'b1; load_v[0] = 1'b0;
        sel_v[0] = SEL_ADD; opd_v[0] = 4'h1;
        #1;
        check("clr_ready", 32'(rdy[0]), 32'h0);
        @(posedge clk); #1;
        check("clr_acc",  32'(acc_o[0]),  32'h0);
        check("clr_zero", 32'(zero_o[0]), 32'h1);
        check("clr_done", 32'(done_o[0]), 32'h0);
        check("clr_noacc_b", 32'(b_o[0]), 32'h7);
        check("clr_cnt",  32'(cnt_o[0]),  32'h4);
        @(negedge clk);
        clr_v[0] = 1'b0;
        #1;
        check("unclr_ready", 32'(rdy[0]), 32'h1);
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        check("retry_busy", 32'(rdy[0]), 32'h0);
        check("retry_a",    32'(a_o[0]), 32'h0);
        check("retry_b",    32'(b_o[0]), 32'h1);
        @(posedge clk); #1;
        check("retry_acc",  32'(acc_o[0]),  32'h1);
        check("retry_done", 32'(done_o[0]), 32'h1);
        check("retry_cnt",  32'(cnt_o[0]),  32'h5);

        // op_count saturation: 5 done so far, 255 more loads
        for (int i = 0; i < 255; i++) begin
            issue(0, 1'b1, SEL_ADD, 4'(i));
            @(posedge clk); #1;
        end
        check("sat_cnt", 32'(cnt_o[0]), 32'hFF);
        check("sat_acc", 32'(acc_o[0]), 32'hE);

        // EXEC_CYCLES=3: load F, then AND 3 held for three cycles
        issue(1, 1'b1, SEL_ADD, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("x3_ld_acc", 32'(acc_o[1]), 32'hF);
        issue(1, 1'b0, SEL_AND, 4'h3);
        for (int c = 0; c < 2; c++) begin
            check("x3_busy", 32'(rdy[1]),    32'h0);
            check("x3_a",    32'(a_o[1]),    32'hF);
            check("x3_b",    32'(b_o[1]),    32'h3);
            check("x3_sel",  32'(sel_o[1]),  32'(SEL_AND));
            check("x3_hold", 32'(acc_o[1]),  32'hF);
            check("x3_done", 32'(done_o[1]), 32'h0);
            @(posedge clk); #1;
        end
        check("x3_busy3", 32'(rdy[1]),   32'h0);
        check("x3_hold3", 32'(acc_o[1]), 32'hF);
        @(posedge clk); #1;
        check("x3_acc",   32'(acc_o[1]),  32'h3);
        check("x3_done1", 32'(done_o[1]), 32'h1);
        check("x3_ready", 32'(rdy[1]),    32'h1);
        check("x3_cnt",   32'(cnt_o[1]),  32'h2);

        // Reset one cycle into DRIVE drops the command
        issue(1, 1'b0, SEL_ADD, 4'h2);
        @(negedge clk);
        rst_v[1] = 1'b1;
        @(posedge clk); #1;
        check("mrst_acc",   32'(acc_o[1]),  32'h0);
        check("mrst_done",  32'(done_o[1]), 32'h0);
        check("mrst_cnt",   32'(cnt_o[1]),  32'h0);
        check("mrst_ready", 32'(rdy[1]),    32'h1);
        check("mrst_a",     32'(a_o[1]),    32'h0);
        @(negedge clk);
        rst_v[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("mrst_nodone", 32'(done_o[1]), 32'h0);
        end
        check("mrst_acc_after", 32'(acc_o[1]), 32'h0);
        check("mrst_cnt_after", 32'(cnt_o[1]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
